// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus ACT/FLAG_TXE launch sequencer
// sitting directly in front of the UART transmitter.
module uart_tx_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int START_TMO  = 64
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            WR_EN,
  input  logic [7:0]      WR_DATA,
  output logic            FULL,
  output logic            EMPTY,
  output logic [ADDR_W:0] LEVEL,
  output logic            OVF,
  input  logic            OVF_CLR,
  output logic            BUSY,
  output logic            ACT,
  output logic [7:0]      TDR,
  input  logic            FLAG_TXE,
  output logic [7:0]      TMO_CNT
);

  localparam int TW =
    (START_TMO > 1) ? $clog2(START_TMO) : 1;
  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(START_TMO - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RETRY,
    WAIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   level;
  logic              ovf;
  logic              act;
  logic [7:0]        tdr;
  logic [7:0]        tmo_cnt;
  logic [TW-1:0]     tmo_q;
  logic [1:0]        rty_q;

  logic full;
  logic empty;
  logic wr_ok;
  logic pop;
  logic tmo_hit;
  logic act_d;

  assign full  = (level == DEPTH);
  assign empty = (level == '0);
  assign wr_ok = WR_EN && !full;

  assign FULL    = full;
  assign EMPTY   = empty;
  assign LEVEL   = level;
  assign OVF     = ovf;
  assign BUSY    = (state_q != IDLE);
  assign ACT     = act;
  assign TDR     = tdr;
  assign TMO_CNT = tmo_cnt;

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // a rejected write outranks a same-cycle clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf <= 1'b0;
    end else if (WR_EN && full) begin
      ovf <= 1'b1;
    end else if (OVF_CLR) begin
      ovf <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && FLAG_TXE) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        if (!FLAG_TXE) begin
          state_d = WAIT;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = RETRY;
        end
      end
      RETRY: begin
        // RETRY plus LOAD keep ACT low four cycles
        if (rty_q == 2'd2) begin
          state_d = LOAD;
        end
      end
      WAIT: begin
        if (FLAG_TXE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign act_d = (state_d == START);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      act     <= 1'b0;
    end else begin
      state_q <= state_d;
      act     <= act_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tdr <= 8'h00;
    end else if (pop) begin
      tdr <= mem[rptr];
    end
  end

  // zero outside START, so it restarts on each entry
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_q <= '0;
      rty_q <= '0;
    end else begin
      if (state_q == START) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
      if (state_q == RETRY) begin
        rty_q <= rty_q + 1'b1;
      end else begin
        rty_q <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt <= 8'h00;
    end else if (tmo_hit && tmo_cnt != 8'hFF) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed scenarios against a
// behavioural transmitter with 2-flop ACT edge detect.
module tb_uart_tx_feeder;

  localparam int FRAME = 10;

  logic       CLK;
  logic       RST_N;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       FULL;
  logic       EMPTY;
  logic [4:0] LEVEL;
  logic       OVF;
  logic       OVF_CLR;
  logic       BUSY;
  logic       ACT;
  logic [7:0] TDR;
  logic       FLAG_TXE;
  logic [7:0] TMO_CNT;

  int total;
  int bad;

  logic       tx_en;
  logic       fflag;
  logic       mflag;
  logic       a1;
  logic       a2;
  int         fcnt;
  logic [7:0] capq [$];

  uart_tx_feeder dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .WR_EN    (WR_EN),
    .WR_DATA  (WR_DATA),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .LEVEL    (LEVEL),
    .OVF      (OVF),
    .OVF_CLR  (OVF_CLR),
    .BUSY     (BUSY),
    .ACT      (ACT),
    .TDR      (TDR),
    .FLAG_TXE (FLAG_TXE),
    .TMO_CNT  (TMO_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign FLAG_TXE = tx_en ? mflag : fflag;

  always @(posedge CLK) begin
    if (!tx_en) begin
      a1    <= 1'b0;
      a2    <= 1'b0;
      mflag <= 1'b1;
      fcnt  <= 0;
    end else begin
      a1 <= ACT;
      a2 <= a1;
      if (mflag && a1 && !a2) begin
        mflag <= 1'b0;
        fcnt  <= 0;
        capq.push_back(TDR);
      end else if (!mflag) begin
        if (fcnt == FRAME - 1) mflag <= 1'b1;
        else fcnt <= fcnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    tx_en   = 1'b0;
    fflag   = 1'b1;
    WR_EN   = 1'b0;
    OVF_CLR = 1'b0;
    RST_N   = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    capq.delete();
  endtask

  task automatic test_reset();
    tx_en   = 1'b0;
    fflag   = 1'b1;
    WR_EN   = 1'b0;
    WR_DATA = 8'h00;
    OVF_CLR = 1'b0;
    RST_N   = 1'b0;
    #3;
    total++;
    if (ACT !== 1'b0 || BUSY !== 1'b0 || OVF !== 1'b0) begin
      bad++;
      $display("FAIL rst_ctl act=%b busy=%b ovf=%b exp 0 0 0",
               ACT, BUSY, OVF);
    end
    total++;
    if (TDR !== 8'h00 || TMO_CNT !== 8'h00) begin
      bad++;
      $display("FAIL rst_data tdr=%h tmo=%h exp 00 00",
               TDR, TMO_CNT);
    end
    total++;
    if (LEVEL !== 5'd0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin
      bad++;
      $display("FAIL rst_fifo lvl=%0d e=%b f=%b exp 0 1 0",
               LEVEL, EMPTY, FULL);
    end
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    tx_en   = 1'b1;
    WR_DATA = 8'hA5;
    WR_EN   = 1'b1;
    tick();
    WR_EN = 1'b0;
    total++;
    if (EMPTY !== 1'b0 || LEVEL !== 5'd1) begin
      bad++;
      $display("FAIL sb_t0 e=%b lvl=%0d exp 0 1", EMPTY, LEVEL);
    end
    tick();
    total++;
    if (TDR !== 8'hA5 || LEVEL !== 5'd0 || ACT !== 1'b0) begin
      bad++;
      $display("FAIL sb_t1 tdr=%h lvl=%0d act=%b exp a5 0 0",
               TDR, LEVEL, ACT);
    end
    tick();
    total++;
    if (ACT !== 1'b1) begin
      bad++;
      $display("FAIL sb_t2_act got=%b exp=1", ACT);
    end
    tick();
    total++;
    if (ACT !== 1'b1 || FLAG_TXE !== 1'b1) begin
      bad++;
      $display("FAIL sb_t3 act=%b flag=%b exp 1 1", ACT, FLAG_TXE);
    end
    tick();
    total++;
    if (FLAG_TXE !== 1'b0 || ACT !== 1'b1) begin
      bad++;
      $display("FAIL sb_t4 flag=%b act=%b exp 0 1", FLAG_TXE, ACT);
    end
    tick();
    total++;
    if (ACT !== 1'b0) begin
      bad++;
      $display("FAIL sb_t5_act got=%b exp=0", ACT);
    end
    n = 0;
    while (FLAG_TXE !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    total++;
    if (BUSY !== 1'b0 || EMPTY !== 1'b1 || n >= 100) begin
      bad++;
      $display("FAIL sb_done busy=%b e=%b wait=%0d exp 0 1 <100",
               BUSY, EMPTY, n);
    end
    total++;
    if (capq.size() != 1 || capq[0] !== 8'hA5) begin
      bad++;
      $display("FAIL sb_txbyte n=%0d exp 1 byte a5", capq.size());
    end
  endtask

  task automatic test_burst();
    int n;
    logic [4:0] peak;
    do_reset();
    tx_en = 1'b1;
    peak  = 5'd0;
    for (int i = 0; i < 16; i++) begin
      WR_DATA = 8'(i);
      WR_EN   = 1'b1;
      tick();
      if (LEVEL > peak) peak = LEVEL;
    end
    WR_EN = 1'b0;
    total++;
    if (peak !== 5'd15) begin
      bad++;
      $display("FAIL burst_peak got=%0d exp=15", peak);
    end
    n = 0;
    while (capq.size() < 16 && n < 2000) begin
      tick();
      n++;
    end
    total++;
    if (capq.size() != 16 || OVF !== 1'b0) begin
      bad++;
      $display("FAIL burst_cnt n=%0d ovf=%b exp 16 0",
               capq.size(), OVF);
    end
    for (int i = 0; i < 16 && i < capq.size(); i++) begin
      total++;
      if (capq[i] !== 8'(i)) begin
        bad++;
        $display("FAIL burst_ord[%0d] got=%h exp=%h",
                 i, capq[i], 8'(i));
      end
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    fflag = 1'b0;
    for (int i = 0; i < 16; i++) begin
      WR_DATA = 8'h40 + 8'(i);
      WR_EN   = 1'b1;
      tick();
    end
    WR_EN = 1'b0;
    total++;
    if (FULL !== 1'b1 || LEVEL !== 5'd16 || OVF !== 1'b0) begin
      bad++;
      $display("FAIL ovf_full f=%b lvl=%0d ovf=%b exp 1 16 0",
               FULL, LEVEL, OVF);
    end
    WR_DATA = 8'hEE;
    WR_EN   = 1'b1;
    tick();
    WR_EN = 1'b0;
    total++;
    if (OVF !== 1'b1 || LEVEL !== 5'd16) begin
      bad++;
      $display("FAIL ovf_drop ovf=%b lvl=%0d exp 1 16", OVF, LEVEL);
    end
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    total++;
    if (OVF !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr got=%b exp=0", OVF);
    end
    WR_DATA = 8'hEF;
    WR_EN   = 1'b1;
    OVF_CLR = 1'b1;
    tick();
    WR_EN   = 1'b0;
    OVF_CLR = 1'b0;
    total++;
    if (OVF !== 1'b1) begin
      bad++;
      $display("FAIL ovf_setwins got=%b exp=1", OVF);
    end
    tx_en = 1'b1;
    n = 0;
    while (capq.size() < 16 && n < 2000) begin
      tick();
      n++;
    end
    tick();
    total++;
    if (capq.size() != 16 || capq[0] !== 8'h40 ||
        capq[15] !== 8'h4F) begin
      bad++;
      $display("FAIL ovf_drain n=%0d exp 16 bytes 40..4f",
               capq.size());
    end
  endtask

  task automatic test_simul();
    int n;
    logic [7:0] exp_b;
    do_reset();
    fflag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WR_DATA = 8'h71 + 8'(i);
      WR_EN   = 1'b1;
      tick();
    end
    total++;
    if (LEVEL !== 5'd3) begin
      bad++;
      $display("FAIL sim_pre lvl=%0d exp=3", LEVEL);
    end
    WR_DATA = 8'h74;
    fflag   = 1'b1;
    tick();
    WR_EN = 1'b0;
    total++;
    if (LEVEL !== 5'd3 || TDR !== 8'h71) begin
      bad++;
      $display("FAIL sim_pop lvl=%0d tdr=%h exp 3 71", LEVEL, TDR);
    end
    tx_en = 1'b1;
    n = 0;
    while (capq.size() < 4 && n < 1000) begin
      tick();
      n++;
    end
    total++;
    if (capq.size() != 4) begin
      bad++;
      $display("FAIL sim_cnt got=%0d exp=4", capq.size());
    end
    for (int i = 0; i < 4 && i < capq.size(); i++) begin
      exp_b = 8'h71 + 8'(i);
      total++;
      if (capq[i] !== exp_b) begin
        bad++;
        $display("FAIL sim_ord[%0d] got=%h exp=%h",
                 i, capq[i], exp_b);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    int hi;
    int lo;
    do_reset();
    fflag   = 1'b1;
    WR_DATA = 8'h3C;
    WR_EN   = 1'b1;
    tick();
    WR_EN = 1'b0;
    n = 0;
    while (ACT !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    hi = 0;
    while (ACT === 1'b1 && hi < 200) begin
      hi++;
      tick();
    end
    total++;
    if (hi != 64 || TMO_CNT !== 8'd1) begin
      bad++;
      $display("FAIL tmo_hi1 hi=%0d tmo=%0d exp 64 1", hi, TMO_CNT);
    end
    lo = 0;
    while (ACT === 1'b0 && lo < 50) begin
      lo++;
      tick();
    end
    total++;
    if (lo != 4 || TDR !== 8'h3C) begin
      bad++;
      $display("FAIL tmo_lo lo=%0d tdr=%h exp 4 3c", lo, TDR);
    end
    hi = 0;
    while (ACT === 1'b1 && hi < 200) begin
      hi++;
      tick();
    end
    total++;
    if (hi != 64 || TMO_CNT !== 8'd2) begin
      bad++;
      $display("FAIL tmo_hi2 hi=%0d tmo=%0d exp 64 2", hi, TMO_CNT);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    tx_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      WR_DATA = 8'h10 + 8'(i);
      WR_EN   = 1'b1;
      tick();
    end
    WR_EN = 1'b0;
    total++;
    if (LEVEL !== 5'd5 || BUSY !== 1'b1 || ACT !== 1'b0 ||
        FLAG_TXE !== 1'b0) begin
      bad++;
      $display("FAIL mid_wait lvl=%0d busy=%b act=%b flag=%b exp 5 1 0 0",
               LEVEL, BUSY, ACT, FLAG_TXE);
    end
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if (ACT !== 1'b0 || LEVEL !== 5'd0 || EMPTY !== 1'b1 ||
        TDR !== 8'h00 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst act=%b lvl=%0d e=%b tdr=%h busy=%b exp 0 0 1 00 0",
               ACT, LEVEL, EMPTY, TDR, BUSY);
    end
    tick();
    RST_N = 1'b1;
    tick();
    WR_DATA = 8'h99;
    WR_EN   = 1'b1;
    tick();
    WR_EN = 1'b0;
    n = 0;
    while (ACT !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if (ACT !== 1'b0 || n >= 100) begin
      bad++;
      $display("FAIL mid_actfall act=%b wait=%0d exp 0 <100", ACT, n);
    end
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and launch sequencer placed directly upstream of the UART transmitter. It accepts bytes from a producer through a single-cycle write strobe and stores them in a FIFO. It presents each byte on `TDR`, then drives the transmitter's rising-edge `ACT` start handshake, paced by the transmitter's `FLAG_TXE` completion flag. Producers can burst up to `FIFO_DEPTH` bytes without tracking line timing.

## Interface
- `FIFO_DEPTH`, default 16: storage entries; power of two, minimum 2.
- `ADDR_W`, default 4: log2(`FIFO_DEPTH`).
- `START_TMO`, default 64: cycles `ACT` is held high waiting for `FLAG_TXE` to fall before a retry.

- `CLK` in 1: system clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `WR_EN` in 1: write strobe, one byte per asserted cycle.
- `WR_DATA` in 8: byte to enqueue.
- `FULL` out 1: `LEVEL == FIFO_DEPTH`.
- `EMPTY` out 1: `LEVEL == 0`.
- `LEVEL` out `ADDR_W+1`: bytes stored; excludes the byte currently on `TDR`.
- `OVF` out 1: sticky flag, set on a rejected write.
- `OVF_CLR` in 1: clears `OVF`.
- `BUSY` out 1: high whenever the FSM is not in `IDLE`.
- `ACT` out 1: start request to the transmitter; launch is on its rising edge.
- `TDR` out 8: byte to transmit; stable from `LOAD` until the next `LOAD`.
- `FLAG_TXE` in 1: transmitter idle/complete flag; high means idle.
- `TMO_CNT` out 8: saturating count of start timeouts.

## Operation
- Reset values (asynchronous):
  - `ACT`=0, `TDR`=0x00, `BUSY`=0, `OVF`=0, `TMO_CNT`=0.
  - `LEVEL`=0, `EMPTY`=1, `FULL`=0, read/write pointers 0, state `IDLE`.
- FIFO write:
  - A write is accepted when `WR_EN` is high and `FULL` is low (registered value) at the clock edge.
  - `WR_EN` with `FULL` high: the byte is dropped and `OVF` is set.
  - If a write is rejected in the same cycle as a pop, the rejection stands.
- FIFO read (pop): occurs only on the `IDLE`→`LOAD` transition.
- Pointers wrap modulo `FIFO_DEPTH`. `LEVEL` is computed as +1 for an accepted write, −1 for a pop, and 0 when both happen in the same cycle.
- `OVF`: when set and `OVF_CLR` coincide, set wins.
- FSM states:
  - `IDLE`: `ACT`=0. If `EMPTY`=0 and `FLAG_TXE`=1, pop the head into `TDR` and go to `LOAD`.
  - `LOAD`: drive `ACT`=1 and go to `START`. `TDR` is already stable, one cycle ahead of the `ACT` rise.
  - `START`: hold `ACT`=1.
    - When `FLAG_TXE`=0 is sampled: `ACT`=0, go to `WAIT`.
    - When the timeout counter reaches `START_TMO`-1 with `FLAG_TXE` still 1: `ACT`=0, increment `TMO_CNT` (saturate at 255), go to `RETRY`.
  - `RETRY`: hold `ACT`=0 for 4 cycles, then go to `LOAD`. No pop occurs, so the same `TDR` byte is re-launched.
  - `WAIT`: `ACT`=0 until `FLAG_TXE`=1, then go to `IDLE`.
- At least one `IDLE` cycle separates consecutive launches. This guarantees `ACT` is low for ≥2 cycles before each rising edge.
- The FSM never pops while `FLAG_TXE`=0.
- Reset mid-frame: all state is cleared immediately and stored bytes are discarded. `ACT` falls asynchronously.

## Timing
- Write accepted at edge t0:
  - `EMPTY` falls after t0.
  - Pop into `TDR` at t1, where `LEVEL` returns to 0.
  - `ACT` rises after t2.
- Against the standard transmitter (2-flop edge detect):
  - `FLAG_TXE` falls after t4.
  - `ACT` falls after t5.
- Throughput is one byte per transmitter frame, plus a 3-cycle launch overhead following `FLAG_TXE` rising.
- Timeout counter is cleared on entry to `START` and counts every cycle spent in `START`.

## Test plan
- Single byte: write 0xA5 with a behavioural transmitter model.
  - `TDR`=0xA5 at t1 and `ACT` rises at t2.
  - `FLAG_TXE` falls at t4 and `ACT` falls at t5.
  - After `FLAG_TXE` rises: `BUSY`=0, `EMPTY`=1.
- Burst: write 0x00..0x0F back-to-back.
  - `LEVEL` peaks at 15 (first byte already popped).
  - The 16 launches come out in order 0x00..0x0F with no `OVF`.
- Overflow: hold `FLAG_TXE`=0 and write 17 bytes.
  - `FULL`=1 after the 16th, and the 17th is dropped with `OVF`=1.
  - `OVF_CLR` pulse → `OVF`=0. `OVF_CLR` on the same cycle as another rejected write → `OVF` stays 1.
- Simultaneous write and pop at `LEVEL`=3: `LEVEL` stays 3 and ordering is preserved.
- Timeout: tie `FLAG_TXE`=1 and write 0x3C.
  - `ACT` is high for 64 cycles, then low for 4 cycles, then rises again with `TDR`=0x3C.
  - `TMO_CNT` increments on every timeout.
- Reset mid-frame: assert `RST_N`=0 during `WAIT` with `LEVEL`=5.
  - Immediately: `ACT`=0, `LEVEL`=0, `EMPTY`=1, `TDR`=0x00, `BUSY`=0.
